// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: sign/zero/upper/branch extension, captured into
// an output register with one skid entry behind it, valid/ready on both sides.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int BR_SH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_ext,
  output logic [TAG_W-1:0] out_tag
);

  if (OUT_W < IN_W + BR_SH) begin : g_bad_width
    $error("imm_extend_pipe: OUT_W must be >= IN_W + BR_SH");
  end

  // State encodes {output valid, skid valid}.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_FULL  = 2'b11
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             w_acc, w_drain, w_ld_out, w_ld_skid, w_sk2out;
  logic [OUT_W-1:0] w_sext, w_ext;
  logic [OUT_W-1:0] r_out_ext, r_sk_ext;
  logic [TAG_W-1:0] r_out_tag, r_sk_tag;

  assign w_sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    case (in_mode)
      2'b00:   w_ext = w_sext;
      2'b01:   w_ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
      2'b10:   w_ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
      default: w_ext = w_sext << BR_SH;
    endcase
  end

  // in_ready comes straight from the state register: no path from out_ready.
  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign out_ext   = r_out_ext;
  assign out_tag   = r_out_tag;
  assign w_acc     = in_valid & in_ready;
  assign w_drain   = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ld_out    = 1'b0;
    w_ld_skid   = 1'b0;
    w_sk2out    = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_acc) begin
          w_state_nxt = S_ONE;
          w_ld_out    = 1'b1;
        end
        S_ONE: begin
          if (w_acc && w_drain) begin
            w_ld_out = 1'b1;
          end else if (w_acc) begin
            w_state_nxt = S_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: if (w_drain) begin
          w_state_nxt = S_ONE;
          w_sk2out    = 1'b1;
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Data registers keep their contents on flush; only the state is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_ext <= '0;
      r_out_tag <= '0;
      r_sk_ext  <= '0;
      r_sk_tag  <= '0;
    end else begin
      if (w_ld_out) begin
        r_out_ext <= w_ext;
        r_out_tag <= in_tag;
      end else if (w_sk2out) begin
        r_out_ext <= r_sk_ext;
        r_out_tag <= r_sk_tag;
      end
      if (w_ld_skid) begin
        r_sk_ext <= w_ext;
        r_sk_tag <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed + random bench for imm_extend_pipe with a queue-based reference model.
module tb_imm_extend_pipe;
  localparam int IN_W = 16, OUT_W = 32, BR_SH = 2, TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm = '0;
  logic [1:0]       in_mode = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_ext;
  logic [TAG_W-1:0] out_tag;

  int total = 0;
  int bad   = 0;
  logic [OUT_W+TAG_W-1:0] exp_q[$];

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_SH(BR_SH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_ext(out_ext), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Reference: treat the immediate as an integer and scale it arithmetically.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint sv, r;
    sv = longint'(imm);
    if (imm >= 16'h8000) sv = sv - 65536;
    case (mode)
      2'd0:    r = sv;
      2'd1:    r = longint'(imm);
      2'd2:    r = longint'(imm) * 65536;
      default: r = sv * 4;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [4:0] tag);
    in_valid = v;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
  endtask

  // Scoreboard: sample handshakes mid-cycle, model the transfers of the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        total++;
        assert (exp_q.size() > 0) else begin
          bad++;
          $error("FAIL sb_extra got=%h exp=none", {out_ext, out_tag});
        end
        if (exp_q.size() > 0) begin
          total++;
          assert ({out_ext, out_tag} === exp_q[0]) else begin
            bad++;
            $error("FAIL sb_order got=%h exp=%h", {out_ext, out_tag}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (flush)
        exp_q.delete();
      else if (in_valid && in_ready)
        exp_q.push_back({ref_ext(in_imm, in_mode), in_tag});
    end
  end

  initial begin
    logic [15:0] rimm;
    logic [1:0]  rmode;
    logic [31:0] held;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_ext",   out_ext,        32'd0);
    chk("rst_out_tag",   32'(out_tag),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic modes, out_ready = 1, one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 16'h8001, 2'd0, 5'd1); step();
    chk("m0_valid", 32'(out_valid), 32'd1);
    chk("m0_sign",  out_ext, 32'hFFFF8001);
    drive(1'b1, 16'h8001, 2'd1, 5'd2); step();
    chk("m1_zero",  out_ext, 32'h00008001);
    drive(1'b1, 16'h1234, 2'd2, 5'd3); step();
    chk("m2_upper", out_ext, 32'h12340000);
    drive(1'b1, 16'hFFFF, 2'd3, 5'd4); step();
    chk("m3_br_neg", out_ext, 32'hFFFFFFFC);
    drive(1'b1, 16'h0004, 2'd3, 5'd5); step();
    chk("m3_br_pos", out_ext, 32'h00000010);
    chk("m3_tag", 32'(out_tag), 32'd5);
    drive(1'b0, 16'h0, 2'd0, 5'd0); step();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Backpressure: 1 and 2 accepted, 3 held off
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 2'd1, 5'd1); step();
    drive(1'b1, 16'h0022, 2'd1, 5'd2); step();
    chk("bp_full_rdy", 32'(in_ready), 32'd0);
    drive(1'b1, 16'h0033, 2'd1, 5'd3);
    held = out_ext;
    step();
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    chk("bp_hold_tag", 32'(out_tag), 32'd1);
    chk("bp_hold_ext", out_ext, held);
    out_ready = 1'b1; step();
    chk("bp_out2", 32'(out_tag), 32'd2);
    step();
    chk("bp_out3", 32'(out_tag), 32'd3);
    drive(1'b0, 16'h0, 2'd0, 5'd0); step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Full throughput random run
    for (int i = 0; i < 100; i++) begin
      rimm  = 16'($urandom);
      rmode = 2'($urandom_range(3, 0));
      drive(1'b1, rimm, rmode, 5'(i));
      step();
      chk("rnd_valid", 32'(out_valid & in_ready), 32'd1);
      chk("rnd_ext", out_ext, ref_ext(rimm, rmode));
    end
    drive(1'b0, 16'h0, 2'd0, 5'd0); step();

    // Flush in FULL with a same-cycle input
    out_ready = 1'b0;
    drive(1'b1, 16'h0101, 2'd0, 5'd10); step();
    drive(1'b1, 16'h0202, 2'd0, 5'd11); step();
    drive(1'b1, 16'h0303, 2'd0, 5'd12);
    flush = 1'b1; step();
    flush = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step(); step();
    chk("fl_nothing", 32'(out_valid), 32'd0);

    // Async reset in the middle of a stall
    out_ready = 1'b0;
    drive(1'b1, 16'h0A0A, 2'd1, 5'd20); step();
    drive(1'b1, 16'h0B0B, 2'd1, 5'd21); step();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_ext",   out_ext, 32'd0);
    chk("ar_tag",   32'(out_tag), 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    drive(1'b1, 16'h7FFF, 2'd0, 5'd7); step();
    chk("ar_post_ext", out_ext, 32'h00007FFF);
    drive(1'b0, 16'h0, 2'd0, 5'd0); step(); step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
